// File: rtl/pipe_reg_hs.sv
// pipe_reg_hs: elastic valid/ready register chain with flush and occupancy count.
// Define PIPE_REG_HS_SKID_EN to add a 2-entry input skid so that in_ready comes straight from a flop.
module pipe_reg_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES = 2
`ifdef PIPE_REG_HS_SKID_EN
  , localparam int CNT_W = $clog2(STAGES+3)
`else
  , localparam int CNT_W = $clog2(STAGES+1)
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      occupancy
);
  logic [STAGES-1:0] v_q, v_d, adv;
  logic [DATA_WIDTH-1:0] d_q [STAGES];
  logic [DATA_WIDTH-1:0] d_d [STAGES];
  logic s0_v;
  logic [DATA_WIDTH-1:0] s0_d;
  // a stage advances when the output drains or any stage at or after it is empty
  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) adv[k] = out_ready | (|(~v_q >> k));
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_st
    logic uv;
    logic [DATA_WIDTH-1:0] ud;
    if (i == 0) begin : g_head
      assign uv = s0_v;
      assign ud = s0_d;
    end else begin : g_body
      assign uv = v_q[i-1];
      assign ud = d_q[i-1];
    end
    assign v_d[i] = flush ? 1'b0 : (adv[i] ? uv : v_q[i]);
    assign d_d[i] = (adv[i] && uv) ? ud : d_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      d_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end
  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
`ifdef PIPE_REG_HS_SKID_EN
  logic [DATA_WIDTH-1:0] sk_q [2];
  logic [DATA_WIDTH-1:0] sk_d [2];
  logic [1:0] sn_q, sn_d;
  logic rdy_q, acc;
  assign acc  = in_valid & rdy_q;
  assign s0_v = (sn_q != 2'd0) | acc;
  assign s0_d = (sn_q != 2'd0) ? sk_q[0] : in_data;
  // held entries feed stage 0 first; a fresh beat bypasses only when the skid is empty
  always_comb begin
    sk_d = sk_q;
    sn_d = sn_q;
    if (sn_q != 2'd0 && adv[0]) begin
      sk_d[0] = sk_q[1];
      sn_d = sn_q - 2'd1;
    end
    if (acc && !(sn_q == 2'd0 && adv[0])) begin
      sk_d[sn_d[0]] = in_data;
      sn_d = sn_d + 2'd1;
    end
    if (flush) sn_d = 2'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_q  <= '{default: '0};
      sn_q  <= 2'd0;
      rdy_q <= 1'b1;
    end else begin
      sk_q  <= sk_d;
      sn_q  <= sn_d;
      rdy_q <= sn_d != 2'd2;
    end
  end
  assign in_ready  = rdy_q;
  assign occupancy = CNT_W'($countones(v_q)) + CNT_W'(sn_q);
`else
  assign s0_v      = in_valid;
  assign s0_d      = in_data;
  assign in_ready  = adv[0];
  assign occupancy = CNT_W'($countones(v_q));
`endif
endmodule

// File: tb/tb_pipe_reg_hs.sv
// tb_pipe_reg_hs: directed checks of pipe_reg_hs with STAGES=2, DATA_WIDTH=32.
module tb_pipe_reg_hs;
`ifdef PIPE_REG_HS_SKID_EN
  localparam int CW = $clog2(2+3);
`else
  localparam int CW = $clog2(2+1);
`endif
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [CW-1:0] occupancy;
  int n_run = 0;
  int n_fail = 0;

  pipe_reg_hs #(.DATA_WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    // T1: async reset mid-clock with a beat held at the output
    in_valid = 1'b1; in_data = 32'hDEAD;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t1_pre_valid", 32'(out_valid), 1);
    chk("t1_pre_data", out_data, 32'hDEAD);
    #3 rst_n = 1'b0;
    #1;
    chk("t1_async_valid", 32'(out_valid), 0);
    chk("t1_async_data", out_data, 0);
    chk("t1_async_occ", 32'(occupancy), 0);
    #2 rst_n = 1'b1;
    // T2: unobstructed stream 1..10
    out_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      in_valid = c < 10;
      in_data = 32'(c + 1);
      tick();
      chk("t2_valid", 32'(out_valid), 32'(c >= 1 && c <= 10));
      if (c >= 1 && c <= 10) chk("t2_data", out_data, 32'(c));
    end
    chk("t2_in_ready", 32'(in_ready), 1);
`ifndef PIPE_REG_HS_SKID_EN
    // T3: backpressure for 5 edges
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h21;
    tick();
    in_data = 32'h22;
    tick();
    chk("t3_full_occ", 32'(occupancy), 2);
    chk("t3_full_in_ready", 32'(in_ready), 0);
    chk("t3_full_valid", 32'(out_valid), 1);
    chk("t3_full_data", out_data, 32'h21);
    in_data = 32'h23;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3_hold_data", out_data, 32'h21);
      chk("t3_hold_occ", 32'(occupancy), 2);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_release_in_ready", 32'(in_ready), 1);
    tick();
    chk("t3_drain0", out_data, 32'h22);
    in_valid = 1'b0;
    tick();
    chk("t3_drain1", out_data, 32'h23);
    chk("t3_drain1_valid", 32'(out_valid), 1);
    tick();
    chk("t3_empty_valid", 32'(out_valid), 0);
    chk("t3_empty_occ", 32'(occupancy), 0);
`endif
    // T4: flush with two beats in flight and a beat offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5;
    tick();
    in_data = 32'h5A;
    tick();
    chk("t4_occ_before", 32'(occupancy), 2);
    flush = 1'b1; in_data = 32'h77;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_valid_after", 32'(out_valid), 0);
    chk("t4_occ_after", 32'(occupancy), 0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t4_no_ghost", 32'(out_valid), 0);
    end
    // T5: reset during a stream, then resume
    in_valid = 1'b1; in_data = 32'h41;
    tick();
    in_data = 32'h42;
    tick();
    in_data = 32'h43;
    tick();
    chk("t5_mid_data", out_data, 32'h42);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 0);
    chk("t5_rst_occ", 32'(occupancy), 0);
    tick();
    rst_n = 1'b1; in_valid = 1'b1; in_data = 32'h50;
    tick();
    chk("t5_resume0_valid", 32'(out_valid), 0);
    in_data = 32'h51;
    tick();
    chk("t5_resume1", out_data, 32'h50);
    in_data = 32'h52;
    tick();
    chk("t5_resume2", out_data, 32'h51);
    in_valid = 1'b0;
    tick();
    chk("t5_resume3", out_data, 32'h52);
    tick();
    chk("t5_drained", 32'(out_valid), 0);
`ifdef PIPE_REG_HS_SKID_EN
    // T6: skid absorbs STAGES+2 beats; in_ready is registered
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_data = 32'h61 + 32'(c);
      chk("t6_accepting", 32'(in_ready), 1);
      tick();
    end
    chk("t6_full_in_ready", 32'(in_ready), 0);
    chk("t6_full_occ", 32'(occupancy), 4);
    in_data = 32'h65;
    tick();
    chk("t6_hold_data", out_data, 32'h61);
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    chk("t6_no_comb_path", 32'(in_ready), 0);
    tick();
    chk("t6_ready_back", 32'(in_ready), 1);
    chk("t6_out1", out_data, 32'h62);
    tick();
    chk("t6_out2", out_data, 32'h63);
    tick();
    chk("t6_out3", out_data, 32'h64);
    tick();
    chk("t6_drained", 32'(out_valid), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
